stepgen_ctrl: RTL and testbench

Host-side sequencer for a bank of N stepgen instances. It owns the shared step-rate prescaler that drives each stepgen `enable`, and double-buffers per-axis velocity plus shared dirtime/steptime/tap so a host frame takes effect atomically on a tick boundary. It also snapshots all axis positions coherently and runs a watchdog that forces velocities to zero when the host stops committing. It sits between the SPI register decoder and the stepgen array.

---
 rtl/pluto_pkg.sv | 19 +
 rtl/tick_div.sv | 28 ++
 rtl/stepgen_ctrl.sv | 181 ++++++++++++++++++
 tb/tb_stepgen_ctrl.sv | 187 ++++++++++++++++++
 4 files changed

// File: rtl/pluto_pkg.sv
// Shared constants and types for the stepgen host sequencer.
package pluto_pkg;

  // Register map
  localparam logic [2:0] ADDR_TIMING = 3'd4;
  localparam logic [2:0] ADDR_CTRL   = 3'd5;

  // Control and timing word bit positions
  localparam int unsigned WD_CLR = 15;
  localparam int unsigned TAP_HI = 15;
  localparam int unsigned TAP_LO = 14;

  // Commit sequencer states
  typedef enum logic {
    IDLE = 1'b0,
    PEND = 1'b1
  } cmt_state_e;

endpackage

// File: rtl/tick_div.sv
// Step-rate prescaler: counts DIV-1 down to 0, tick is high while the count is 0.
module tick_div #(
  parameter int unsigned DIV = 40
) (
  input  logic clk,
  input  logic reset,
  output logic tick
);

  localparam int unsigned CW = (DIV > 1) ? $clog2(DIV) : 1;
  localparam logic [CW-1:0] RELOAD = CW'(DIV - 1);

  logic [CW-1:0] cnt_q;

  // Down-counter with reload on zero
  always_ff @(posedge clk) begin
    if (reset) begin
      cnt_q <= RELOAD;
    end else if (cnt_q == '0) begin
      cnt_q <= RELOAD;
    end else begin
      cnt_q <= cnt_q - CW'(1);
    end
  end

  assign tick = (cnt_q == '0);

endmodule

// File: rtl/stepgen_ctrl.sv
// Host-side sequencer for a bank of stepgens: prescaler, double-buffered
// velocity/timing registers, coherent position snapshot and watchdog.
module stepgen_ctrl
  import pluto_pkg::*;
#(
  parameter int unsigned N        = 4,
  parameter int unsigned W        = 12,
  parameter int unsigned F        = 10,
  parameter int unsigned T        = 5,
  parameter int unsigned DIV      = 40,
  parameter logic [15:0] WD_TICKS = 16'd50000
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 wr_en,
  input  logic [2:0]           wr_addr,
  input  logic [15:0]          wr_data,
  input  logic                 commit,
  input  logic                 snap,
  input  logic [N*(W+F)-1:0]   pos_in,
  output logic [N-1:0]         step_en,
  output logic [N*(F+1)-1:0]   vel_out,
  output logic [T-1:0]         dirtime,
  output logic [T-1:0]         steptime,
  output logic [1:0]           tap,
  output logic [N*(W+F)-1:0]   pos_snap,
  output logic                 snap_valid,
  output logic                 pending,
  output logic                 wd_trip
);

  logic tick;
  logic xfer;

  logic [N-1:0]      vel_we;
  logic              tim_we;
  logic              ctl_we;
  logic              wd_clr;

  logic [N-1:0][F:0] vel_sh_q, vel_act_q;
  logic [T-1:0]      dir_sh_q, dir_act_q;
  logic [T-1:0]      stp_sh_q, stp_act_q;
  logic [1:0]        tap_sh_q, tap_act_q;
  logic [N-1:0]      axis_en_q;

  logic [15:0]       wd_cnt_q;
  logic              wd_trip_q;

  logic [N*(W+F)-1:0] pos_snap_q;
  logic               snap_valid_q;

  cmt_state_e state_q, state_d;

  tick_div #(
    .DIV (DIV)
  ) u_tick_div (
    .clk   (clk),
    .reset (reset),
    .tick  (tick)
  );

  // Register write address decode
  always_comb begin
    vel_we = '0;
    tim_we = 1'b0;
    ctl_we = 1'b0;
    if (wr_en) begin
      if (wr_addr == ADDR_TIMING) begin
        tim_we = 1'b1;
      end else if (wr_addr == ADDR_CTRL) begin
        ctl_we = 1'b1;
      end else begin
        for (int i = 0; i < N; i++) begin
          if (wr_addr == 3'(i)) vel_we[i] = 1'b1;
        end
      end
    end
  end

  assign wd_clr = ctl_we & wr_data[WD_CLR];

  // Commit FSM state register
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Commit FSM next state; a commit on a tick cycle waits for the following tick
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:    if (commit) state_d = PEND;
      PEND:    if (tick)   state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Commit FSM outputs
  always_comb begin
    pending = (state_q == PEND);
    xfer    = (state_q == PEND) & tick;
  end

  // Shadow writes and shadow-to-active transfer; transfer takes pre-write shadow values
  always_ff @(posedge clk) begin
    if (reset) begin
      vel_sh_q  <= '0;
      vel_act_q <= '0;
      dir_sh_q  <= '0;
      dir_act_q <= '0;
      stp_sh_q  <= '0;
      stp_act_q <= '0;
      tap_sh_q  <= '0;
      tap_act_q <= '0;
      axis_en_q <= '0;
    end else begin
      for (int i = 0; i < N; i++) begin
        if (vel_we[i]) vel_sh_q[i] <= wr_data[F:0];
      end
      if (tim_we) begin
        stp_sh_q <= wr_data[T-1:0];
        dir_sh_q <= wr_data[2*T-1:T];
        tap_sh_q <= wr_data[TAP_HI:TAP_LO];
      end
      if (ctl_we) axis_en_q <= wr_data[N-1:0];
      if (xfer) begin
        vel_act_q <= vel_sh_q;
        dir_act_q <= dir_sh_q;
        stp_act_q <= stp_sh_q;
        tap_act_q <= tap_sh_q;
      end
    end
  end

  // Watchdog: host clear beats transfer reload beats tick decrement; holds at 0
  always_ff @(posedge clk) begin
    if (reset) begin
      wd_cnt_q  <= WD_TICKS;
      wd_trip_q <= 1'b0;
    end else if (wd_clr) begin
      wd_cnt_q  <= WD_TICKS;
      wd_trip_q <= 1'b0;
    end else if (xfer) begin
      wd_cnt_q  <= WD_TICKS;
    end else if (tick && !wd_trip_q) begin
      if (wd_cnt_q == 16'd1) begin
        wd_cnt_q  <= 16'd0;
        wd_trip_q <= 1'b1;
      end else if (wd_cnt_q != 16'd0) begin
        wd_cnt_q  <= wd_cnt_q - 16'd1;
      end
    end
  end

  // Position snapshot with one-cycle valid pulse
  always_ff @(posedge clk) begin
    if (reset) begin
      pos_snap_q   <= '0;
      snap_valid_q <= 1'b0;
    end else begin
      snap_valid_q <= snap;
      if (snap) pos_snap_q <= pos_in;
    end
  end

  // Output drive; a trip masks velocity and enables but keeps active registers
  always_comb begin
    step_en    = tick ? (axis_en_q & ~{N{wd_trip_q}}) : '0;
    vel_out    = wd_trip_q ? '0 : vel_act_q;
    dirtime    = dir_act_q;
    steptime   = stp_act_q;
    tap        = tap_act_q;
    pos_snap   = pos_snap_q;
    snap_valid = snap_valid_q;
    wd_trip    = wd_trip_q;
  end

endmodule

// File: tb/tb_stepgen_ctrl.sv
// Randomised bench for stepgen_ctrl against a cycle-level behavioural model.
module tb_stepgen_ctrl;

  localparam int N   = 4;
  localparam int W   = 12;
  localparam int F   = 10;
  localparam int T   = 5;
  localparam int DIV = 10;
  localparam logic [15:0] WD = 16'd3;
  localparam int PW  = W + F;
  localparam int NCYC = 3000;

  logic clk = 1'b0;
  logic reset = 1'b1;
  logic wr_en = 1'b0;
  logic [2:0] wr_addr = '0;
  logic [15:0] wr_data = '0;
  logic commit = 1'b0;
  logic snap = 1'b0;
  logic [N*PW-1:0] pos_in = '0;

  logic [N-1:0]       step_en;
  logic [N*(F+1)-1:0] vel_out;
  logic [T-1:0]       dirtime, steptime;
  logic [1:0]         tap;
  logic [N*PW-1:0]    pos_snap;
  logic               snap_valid, pending, wd_trip;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  stepgen_ctrl #(
    .N        (N),
    .W        (W),
    .F        (F),
    .T        (T),
    .DIV      (DIV),
    .WD_TICKS (WD)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .wr_en      (wr_en),
    .wr_addr    (wr_addr),
    .wr_data    (wr_data),
    .commit     (commit),
    .snap       (snap),
    .pos_in     (pos_in),
    .step_en    (step_en),
    .vel_out    (vel_out),
    .dirtime    (dirtime),
    .steptime   (steptime),
    .tap        (tap),
    .pos_snap   (pos_snap),
    .snap_valid (snap_valid),
    .pending    (pending),
    .wd_trip    (wd_trip)
  );

  task automatic check_eq(input string tag, input logic [127:0] got, input logic [127:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Behavioural model state
  logic [F:0]      m_vsh [N];
  logic [F:0]      m_vact[N];
  logic [T-1:0]    m_dsh, m_dact, m_ssh, m_sact;
  logic [1:0]      m_tsh, m_tact;
  logic [N-1:0]    m_en;
  logic [N*PW-1:0] m_psnap;
  bit              m_trip, m_pend, m_sv;
  int              m_wd;
  int              m_cyc;  // cycles since reset release, 1 = first cycle

  function automatic bit m_tick();
    return (m_cyc % DIV) == 0;
  endfunction

  task automatic model_reset();
    for (int i = 0; i < N; i++) begin
      m_vsh[i]  = '0;
      m_vact[i] = '0;
    end
    m_dsh = '0; m_dact = '0; m_ssh = '0; m_sact = '0;
    m_tsh = '0; m_tact = '0; m_en = '0; m_psnap = '0;
    m_trip = 1'b0; m_pend = 1'b0; m_sv = 1'b0;
    m_wd = int'(WD);
    m_cyc = 1;
  endtask

  task automatic compare_outputs();
    logic [N*(F+1)-1:0] ev;
    logic [N-1:0] es;
    ev = '0;
    if (!m_trip) for (int i = 0; i < N; i++) ev[i*(F+1) +: F+1] = m_vact[i];
    es = (m_tick() && !m_trip) ? m_en : '0;
    check_eq("step_en", 128'(step_en), 128'(es));
    check_eq("vel_out", 128'(vel_out), 128'(ev));
    check_eq("dirtime", 128'(dirtime), 128'(m_dact));
    check_eq("steptime", 128'(steptime), 128'(m_sact));
    check_eq("tap", 128'(tap), 128'(m_tact));
    check_eq("pending", 128'(pending), 128'(m_pend));
    check_eq("wd_trip", 128'(wd_trip), 128'(m_trip));
    check_eq("snap_valid", 128'(snap_valid), 128'(m_sv));
    check_eq("pos_snap", 128'(pos_snap), 128'(m_psnap));
  endtask

  // Advance the model across one clock edge using the inputs currently driven
  task automatic model_step();
    bit tk, xf, clr;
    if (reset) begin
      model_reset();
      return;
    end
    tk = m_tick();
    xf = m_pend && tk;
    if (xf) begin
      for (int i = 0; i < N; i++) m_vact[i] = m_vsh[i];
      m_dact = m_dsh;
      m_sact = m_ssh;
      m_tact = m_tsh;
    end
    clr = 1'b0;
    if (wr_en) begin
      if (wr_addr == 3'd4) begin
        m_ssh = wr_data[T-1:0];
        m_dsh = wr_data[2*T-1:T];
        m_tsh = wr_data[15:14];
      end else if (wr_addr == 3'd5) begin
        m_en = wr_data[N-1:0];
        clr  = wr_data[15];
      end else if (int'(wr_addr) < N) begin
        m_vsh[int'(wr_addr)] = wr_data[F:0];
      end
    end
    if (clr) begin
      m_wd = int'(WD);
      m_trip = 1'b0;
    end else if (xf) begin
      m_wd = int'(WD);
    end else if (tk && !m_trip) begin
      if (m_wd == 1) begin
        m_wd = 0;
        m_trip = 1'b1;
      end else if (m_wd > 0) begin
        m_wd = m_wd - 1;
      end
    end
    if (xf) m_pend = 1'b0;
    else if (commit) m_pend = 1'b1;
    m_sv = snap;
    if (snap) m_psnap = pos_in;
    m_cyc++;
  endtask

  initial begin
    bit sparse;
    repeat (3) @(posedge clk);
    model_reset();
    for (int c = 0; c < NCYC; c++) begin
      @(negedge clk);
      compare_outputs();
      // Alternate busy phases (frequent commits) with sparse ones that let the watchdog trip
      sparse  = ((c / 400) % 2) == 1;
      reset   = (c == 0) ? 1'b0 : ($urandom_range(599, 0) == 0);
      wr_en   = ($urandom_range(3, 0) == 0);
      wr_addr = 3'($urandom_range(7, 0));
      wr_data = 16'($urandom);
      if (wr_addr == 3'd5) wr_data[15] = ($urandom_range(7, 0) == 0);
      if (sparse) commit = ($urandom_range(39, 0) == 0);
      else commit = ($urandom_range(9, 0) == 0) || (m_tick() && $urandom_range(2, 0) == 0);
      snap    = ($urandom_range(7, 0) == 0);
      pos_in  = (N*PW)'({$urandom, $urandom, $urandom});
      model_step();
    end
    @(negedge clk);
    compare_outputs();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
